// File: rtl/exec_stage_mc.sv
// Execute stage: operand forwarding, immediate select, single-cycle ALU and an iterative
// shift-add / restoring mul-div unit, all registered into the EX/MEM boundary.
module exec_stage_mc #(
   parameter int unsigned W      = 8,
   parameter int unsigned MULDIV = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         stall_in,
   input  logic         in_valid,
   input  logic [W-1:0] reg1,
   input  logic [W-1:0] reg2,
   input  logic [W-1:0] immediate,
   input  logic         alu_src,
   input  logic         dir,
   input  logic [3:0]   opcode,
   input  logic         is_unsigned,
   input  logic [1:0]   fwd_a,
   input  logic [1:0]   fwd_b,
   input  logic [W-1:0] fwd_mem,
   input  logic [W-1:0] fwd_wb,
   output logic         out_valid,
   output logic [W-1:0] alu_result,
   output logic         zero,
   output logic         branch_taken,
   output logic         busy
);

   localparam int unsigned SHW = $clog2(W);
   localparam int unsigned CW  = $clog2(W);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e           state_q;
   logic             busy_q;
   logic [2*W-1:0]   acc_q;
   logic [W-1:0]     divisor_q;
   logic [1:0]       op_q;
   logic             qneg_q, rneg_q, div0_q;
   logic [CW-1:0]    cnt_q;

   logic [W-1:0]     op_a, op_b_fwd, op_b, sra, alu_res, a_mag, b_mag, md_res;
   logic [W-1:0]     quo_s, rem_s;
   logic [2*W-1:0]   prod_s, mul_next, div_next;
   logic [W:0]       mul_sum, r_sh, r_diff;
   logic [SHW-1:0]   shamt;
   logic             alu_br, lt, a_neg, b_neg, is_md, accept;

   always_comb begin
      op_a = reg1;
      case (fwd_a)
         2'b01:   op_a = fwd_wb;
         2'b10:   op_a = fwd_mem;
         default: op_a = reg1;
      endcase
      op_b_fwd = reg2;
      case (fwd_b)
         2'b01:   op_b_fwd = fwd_wb;
         2'b10:   op_b_fwd = fwd_mem;
         default: op_b_fwd = reg2;
      endcase
      op_b = alu_src ? immediate : op_b_fwd;
   end

   assign shamt = op_b[SHW-1:0];
   // Kept as its own signal so the arithmetic shift is not widened into an unsigned mux.
   assign sra   = $signed(op_a) >>> shamt;
   assign lt    = is_unsigned ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

   always_comb begin
      alu_res = '0;
      alu_br  = 1'b0;
      case (opcode)
         4'h0: alu_res = op_a + op_b;
         4'h1: alu_res = op_a - op_b;
         4'h2: alu_res = op_a & op_b;
         4'h3: alu_res = op_a | op_b;
         4'h4: alu_res = op_a ^ op_b;
         4'h5: alu_res = !dir ? (op_a << shamt) : (is_unsigned ? (op_a >> shamt) : sra);
         4'h6: alu_res = {{(W-1){1'b0}}, lt};
         4'h7: begin alu_res = op_a - op_b; alu_br = (op_a == op_b); end
         4'h8: begin alu_res = op_a - op_b; alu_br = (op_a != op_b); end
         4'h9: begin alu_res = op_a - op_b; alu_br = lt; end
         4'hE: alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   assign is_md  = (MULDIV != 0) && (opcode >= 4'hA) && (opcode <= 4'hD);
   assign accept = in_valid & ~busy_q & ~stall_in & ~flush;
   assign busy   = busy_q | (accept & is_md);

   assign a_neg = ~is_unsigned & op_a[W-1];
   assign b_neg = ~is_unsigned & op_b[W-1];
   assign a_mag = a_neg ? -op_a : op_a;
   assign b_mag = b_neg ? -op_b : op_b;

   // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
   assign mul_next = {mul_sum, acc_q[W-1:1]};
   assign r_sh     = acc_q[2*W-1:W-1];
   assign r_diff   = r_sh - {1'b0, divisor_q};
   assign div_next = r_diff[W] ? {r_sh[W-1:0], acc_q[W-2:0], 1'b0}
                               : {r_diff[W-1:0], acc_q[W-2:0], 1'b1};

   always_comb begin
      prod_s = qneg_q ? -acc_q : acc_q;
      quo_s  = qneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem_s  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      case (op_q)
         2'b10:   md_res = prod_s[W-1:0];
         2'b11:   md_res = prod_s[2*W-1:W];
         2'b00:   md_res = div0_q ? '1 : quo_s;
         default: md_res = rem_s;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         busy_q       <= 1'b0;
         out_valid    <= 1'b0;
         alu_result   <= '0;
         zero         <= 1'b0;
         branch_taken <= 1'b0;
         acc_q        <= '0;
         divisor_q    <= '0;
         op_q         <= '0;
         qneg_q       <= 1'b0;
         rneg_q       <= 1'b0;
         div0_q       <= 1'b0;
         cnt_q        <= '0;
      end else if (flush) begin
         state_q      <= StIdle;
         busy_q       <= 1'b0;
         out_valid    <= 1'b0;
         alu_result   <= '0;
         zero         <= 1'b0;
         branch_taken <= 1'b0;
      end else begin
         if (!stall_in) out_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept && is_md) begin
                  acc_q     <= {{W{1'b0}}, a_mag};
                  divisor_q <= b_mag;
                  op_q      <= opcode[1:0];
                  qneg_q    <= a_neg ^ b_neg;
                  rneg_q    <= a_neg;
                  div0_q    <= (op_b == '0);
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= opcode[2] ? StDiv : StMul;
               end else if (accept) begin
                  out_valid    <= 1'b1;
                  alu_result   <= alu_res;
                  zero         <= (alu_res == '0);
                  branch_taken <= alu_br;
               end
            end
            StMul, StDiv: begin
               acc_q <= (state_q == StMul) ? mul_next : div_next;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(W-1)) state_q <= StDone;
            end
            StDone: begin
               if (!stall_in) begin
                  out_valid    <= 1'b1;
                  alu_result   <= md_res;
                  zero         <= (md_res == '0);
                  branch_taken <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc: expected results are queued at issue and
// compared when the stage presents a fresh out_valid.
module tb_exec_stage_mc;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset, flush, stall_in, in_valid, alu_src, dir, is_unsigned;
   logic [W-1:0] reg1, reg2, immediate, fwd_mem, fwd_wb, alu_result;
   logic [3:0] opcode;
   logic [1:0] fwd_a, fwd_b;
   logic out_valid, zero, branch_taken, busy;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [7:0] res;
      logic       z;
      logic       br;
   } exp_t;

   exp_t sbq[$];
   logic [7:0] last_res = '0;

   always #5 clk = ~clk;

   exec_stage_mc #(.W(W), .MULDIV(1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .stall_in(stall_in), .in_valid(in_valid),
      .reg1(reg1), .reg2(reg2), .immediate(immediate), .alu_src(alu_src), .dir(dir),
      .opcode(opcode), .is_unsigned(is_unsigned), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .out_valid(out_valid), .alu_result(alu_result),
      .zero(zero), .branch_taken(branch_taken), .busy(busy)
   );

   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic uns, input logic d);
      exp_t e;
      int sa, sb;
      logic [15:0] p;
      logic [2:0] sh;
      sa = int'($signed(a));
      sb = int'($signed(b));
      sh = b[2:0];
      e.br = 1'b0;
      e.res = 8'h00;
      case (op)
         4'h0: e.res = a + b;
         4'h1: e.res = a - b;
         4'h2: e.res = a & b;
         4'h3: e.res = a | b;
         4'h4: e.res = a ^ b;
         4'h5: begin
            if (!d) e.res = a << sh;
            else if (uns) e.res = a >> sh;
            else e.res = $signed(a) >>> sh;
         end
         4'h6: e.res = {7'b0, uns ? (a < b) : (sa < sb)};
         4'h7, 4'h8, 4'h9: begin
            e.res = a - b;
            if (op == 4'h7) e.br = (a == b);
            else if (op == 4'h8) e.br = (a != b);
            else e.br = uns ? (a < b) : (sa < sb);
         end
         4'hA, 4'hB: begin
            p = uns ? (16'(a) * 16'(b)) : 16'(sa * sb);
            e.res = (op == 4'hA) ? p[7:0] : p[15:8];
         end
         4'hC: e.res = (b == 8'h00) ? 8'hFF : (uns ? a / b : 8'(sa / sb));
         4'hD: e.res = (b == 8'h00) ? a : (uns ? a % b : 8'(sa % sb));
         4'hE: e.res = b;
         default: e.res = 8'h00;
      endcase
      e.z = (e.res == 8'h00);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; a fresh result (edge not stalled or flushed) is checked against the queue.
   task automatic tick();
      logic st;
      exp_t e;
      st = stall_in | flush;
      @(posedge clk);
      #1;
      if (out_valid && !st) begin
         if (sbq.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("res", 32'(alu_result), 32'(e.res));
            chk("zero", 32'(zero), 32'(e.z));
            chk("branch", 32'(branch_taken), 32'(e.br));
            last_res = e.res;
         end
      end
   endtask

   task automatic send(input logic [3:0] op, input logic uns, input logic d,
                       input logic [7:0] ea, input logic [7:0] eb);
      opcode = op; is_unsigned = uns; dir = d; in_valid = 1'b1;
      sbq.push_back(model(op, ea, eb, uns, d));
      tick();
      in_valid = 1'b0;
      chk("lat1_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic uns, input logic d);
      reg1 = a; reg2 = b; alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
      send(op, uns, d, a, b);
   endtask

   task automatic md(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic uns);
      reg1 = a; reg2 = b; alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
      opcode = op; is_unsigned = uns; in_valid = 1'b1;
      sbq.push_back(model(op, a, b, uns, 1'b0));
      #1 chk("busy_comb", 32'(busy), 32'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < W + 1; i++) begin
         chk("md_busy", 32'(busy), 32'd1);
         chk("md_early_valid", 32'(out_valid), 32'd0);
         tick();
      end
      chk("md_valid", 32'(out_valid), 32'd1);
      chk("md_busy_drop", 32'(busy), 32'd0);
      tick();
      chk("md_pulse", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; stall_in = 1'b0; in_valid = 1'b0; alu_src = 1'b0;
      dir = 1'b0; is_unsigned = 1'b0; reg1 = '0; reg2 = '0; immediate = '0;
      fwd_mem = '0; fwd_wb = '0; opcode = 4'h0; fwd_a = 2'b00; fwd_b = 2'b00;
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_res", 32'(alu_result), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_branch", 32'(branch_taken), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // Forwarding and immediate select.
      reg1 = 8'h33; fwd_mem = 8'h05; reg2 = 8'h03; fwd_a = 2'b10; fwd_b = 2'b00;
      alu_src = 1'b0;
      send(4'h0, 1'b0, 1'b0, 8'h05, 8'h03);
      fwd_a = 2'b01; fwd_wb = 8'h20; fwd_b = 2'b11; reg2 = 8'h20;
      send(4'h1, 1'b0, 1'b0, 8'h20, 8'h20);
      reg1 = 8'h01; fwd_a = 2'b00; fwd_b = 2'b10; fwd_mem = 8'h55; alu_src = 1'b1;
      immediate = 8'h10;
      send(4'h0, 1'b0, 1'b0, 8'h01, 8'h10);

      // Logic, shifts, compares, branches.
      alu(4'h2, 8'hC3, 8'h5A, 1'b0, 1'b0);
      alu(4'h3, 8'hC3, 8'h5A, 1'b0, 1'b0);
      alu(4'h4, 8'hC3, 8'hC3, 1'b0, 1'b0);
      alu(4'h5, 8'h90, 8'h02, 1'b0, 1'b0);
      alu(4'h5, 8'h90, 8'h02, 1'b0, 1'b1);
      alu(4'h5, 8'h90, 8'h02, 1'b1, 1'b1);
      alu(4'h6, 8'hFE, 8'h01, 1'b0, 1'b0);
      alu(4'h6, 8'hFE, 8'h01, 1'b1, 1'b0);
      alu(4'h9, 8'hFE, 8'h01, 1'b0, 1'b0);
      alu(4'h9, 8'hFE, 8'h01, 1'b1, 1'b0);
      alu(4'h7, 8'h44, 8'h44, 1'b0, 1'b0);
      alu(4'h8, 8'h44, 8'h44, 1'b0, 1'b0);
      alu(4'hE, 8'h12, 8'h9C, 1'b0, 1'b0);
      alu(4'hF, 8'h12, 8'h9C, 1'b0, 1'b0);

      // Multiply / divide including the division corner cases.
      md(4'hA, 8'hF9, 8'h05, 1'b0);
      md(4'hB, 8'hF9, 8'h05, 1'b0);
      md(4'hB, 8'hF9, 8'h05, 1'b1);
      md(4'hC, 8'h07, 8'h00, 1'b0);
      md(4'hD, 8'h07, 8'h00, 1'b0);
      md(4'hC, 8'h80, 8'hFF, 1'b0);
      md(4'hD, 8'h80, 8'hFF, 1'b0);
      md(4'hC, 8'hF9, 8'h02, 1'b0);
      md(4'hD, 8'hF9, 8'h02, 1'b0);
      md(4'hC, 8'hC8, 8'h07, 1'b1);

      // Flush a division mid-way; branch_taken was set by the preceding BEQ.
      alu(4'h7, 8'h03, 8'h03, 1'b0, 1'b0);
      reg1 = 8'h07; reg2 = 8'h02; opcode = 4'hC; is_unsigned = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_branch", 32'(branch_taken), 32'd0);
      chk("flush_res", 32'(alu_result), 32'd0);
      alu(4'h0, 8'h21, 8'h12, 1'b0, 1'b0);

      // Stall held in DONE.
      reg1 = 8'h06; reg2 = 8'h07; opcode = 4'hA; is_unsigned = 1'b0; in_valid = 1'b1;
      sbq.push_back(model(4'hA, 8'h06, 8'h07, 1'b0, 1'b0));
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < W; i++) tick();
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_busy", 32'(busy), 32'd1);
         chk("stall_valid", 32'(out_valid), 32'd0);
         chk("stall_hold", 32'(alu_result), 32'(last_res));
      end
      stall_in = 1'b0;
      tick();
      chk("stall_release_valid", 32'(out_valid), 32'd1);
      tick();
      chk("stall_release_pulse", 32'(out_valid), 32'd0);

      // Stall on a single-cycle op holds everything including out_valid.
      alu(4'h0, 8'h04, 8'h04, 1'b0, 1'b0);
      reg1 = 8'h01; reg2 = 8'h01; stall_in = 1'b1; in_valid = 1'b1; opcode = 4'h0;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", 32'(alu_result), 32'(last_res));
      stall_in = 1'b0;
      send(4'h0, 1'b0, 1'b0, 8'h01, 8'h01);
      tick();
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_hold", 32'(alu_result), 32'(last_res));

      // Asynchronous reset in the middle of a division.
      reg1 = 8'h09; reg2 = 8'h03; opcode = 4'hC; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_res", 32'(alu_result), 32'd0);
      reset = 1'b0;
      alu(4'h0, 8'h01, 8'h01, 1'b0, 1'b0);
      tick();

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
